debounce_bank: RTL and testbench



---
 rtl/debounce_bank.sv | 117 +++++++++++
 tb/tb_debounce_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// N-channel pushbutton conditioner: synchronizer, per-channel stable-time filter, edge pulses.
// Optional auto-repeat of held buttons is built when DEBOUNCE_BANK_REPEAT_EN is defined.
module debounce_bank #(
  parameter int N_CH          = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 20,
  parameter int STABLE_CYC    = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_repeat
);

  localparam bit CFG_OK = (SYNC_STAGES >= 2) && (STABLE_CYC >= 1) &&
                          (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  if (!CFG_OK) begin : g_cfg_invalid
    $error("debounce_bank: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(STABLE_CYC - 1);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  sync;
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_nxt [N_CH];
  logic [N_CH-1:0]  level_nxt;
  logic [N_CH-1:0]  rise_nxt;
  logic [N_CH-1:0]  fall_nxt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Any cycle where sync matches the accepted level restarts the stability count.
  always_comb begin
    level_nxt = btn_level;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = '0;
      if (sync[i] != btn_level[i]) begin
        if (cnt_q[i] == CNT_TC) begin
          level_nxt[i] = sync[i];
          rise_nxt[i]  = sync[i];
          fall_nxt[i]  = ~sync[i];
        end else begin
          cnt_nxt[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      btn_level <= level_nxt;
      btn_rise  <= rise_nxt;
      btn_fall  <= fall_nxt;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_TC  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_TC = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt [N_CH];
  logic [N_CH-1:0]  rep_first;

  // Keyed off the next level so repeats stop on the very edge that raises btn_fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_repeat <= '0;
      rep_first  <= '1;
      for (int i = 0; i < N_CH; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!level_nxt[i] || rise_nxt[i]) begin
          rep_cnt[i]    <= '0;
          rep_first[i]  <= 1'b1;
          btn_repeat[i] <= 1'b0;
        end else if (rep_cnt[i] == (rep_first[i] ? DELAY_TC : PERIOD_TC)) begin
          rep_cnt[i]    <= '0;
          rep_first[i]  <= 1'b0;
          btn_repeat[i] <= 1'b1;
        end else begin
          rep_cnt[i]    <= rep_cnt[i] + 1'b1;
          btn_repeat[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: vector table, directed corner sequences and
// randomized stimulus against a history-based reference model.
module tb_debounce_bank;
  localparam int N  = 5;
  localparam int SS = 2;
  localparam int CW = 4;
  localparam int ST = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level, btn_rise, btn_fall, btn_repeat;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH(N), .SYNC_STAGES(SS), .CNT_W(CW), .STABLE_CYC(ST),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_rise(btn_rise),
    .btn_fall(btn_fall), .btn_repeat(btn_repeat)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int rise_cnt[N], fall_cnt[N], rep_cnt[N];
  int rise_cyc[N], fall_cyc[N];

  // reference model state
  logic [N-1:0] pipe_m[$];
  bit           hist_m[N][$];
  logic [N-1:0] lvl_m, rise_m, fall_m, rep_m;
  int           age_m[N];

  typedef struct {
    logic         r;
    logic [N-1:0] b;
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
  endtask

  // A level is accepted once the last ST synchronized samples all disagree with it;
  // a repeat fires at ages RD, RD+RP, RD+2RP ... counted from the rise cycle.
  task automatic model_edge(input logic r, input logic [N-1:0] b);
    logic [N-1:0] s;
    bit all_diff;
    if (r) begin
      pipe_m = {};
      for (int k = 0; k < SS; k++) pipe_m.push_back('0);
      for (int ch = 0; ch < N; ch++) begin
        hist_m[ch].delete();
        age_m[ch] = 0;
      end
      lvl_m = '0; rise_m = '0; fall_m = '0; rep_m = '0;
      return;
    end
    s = pipe_m.pop_front();
    pipe_m.push_back(b);
    rise_m = '0; fall_m = '0; rep_m = '0;
    for (int ch = 0; ch < N; ch++) begin
      hist_m[ch].push_back(s[ch]);
      if (hist_m[ch].size() > ST) void'(hist_m[ch].pop_front());
      if (hist_m[ch].size() == ST) begin
        all_diff = 1'b1;
        foreach (hist_m[ch][k]) if (hist_m[ch][k] == lvl_m[ch]) all_diff = 1'b0;
        if (all_diff) begin
          lvl_m[ch] = ~lvl_m[ch];
          if (lvl_m[ch]) rise_m[ch] = 1'b1;
          else fall_m[ch] = 1'b1;
          hist_m[ch].delete();
        end
      end
      if (rise_m[ch]) age_m[ch] = 0;
      else if (lvl_m[ch]) begin
        age_m[ch]++;
        if (REP_EN && age_m[ch] >= RD && (age_m[ch] - RD) % RP == 0) rep_m[ch] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] b);
    @(negedge clk);
    rst = r;
    btn_in = b;
    @(posedge clk);
    model_edge(r, b);
    cyc++;
    #1;
    for (int ch = 0; ch < N; ch++) begin
      if (btn_rise[ch]) begin rise_cnt[ch]++; rise_cyc[ch] = cyc; end
      if (btn_fall[ch]) begin fall_cnt[ch]++; fall_cyc[ch] = cyc; end
      if (btn_repeat[ch]) rep_cnt[ch]++;
    end
    chk("model_level",  32'(btn_level),  32'(lvl_m));
    chk("model_rise",   32'(btn_rise),   32'(rise_m));
    chk("model_fall",   32'(btn_fall),   32'(fall_m));
    chk("model_repeat", 32'(btn_repeat), 32'(rep_m));
  endtask

  initial begin
    int base, p, rc, c5;
    int bounce[9];
    logic [N-1:0] cur;

    rst = 1'b1;
    btn_in = '0;
    for (int k = 0; k < SS; k++) pipe_m.push_back('0);
    lvl_m = '0; rise_m = '0; fall_m = '0; rep_m = '0;
    for (int ch = 0; ch < N; ch++) begin
      rise_cnt[ch] = 0; fall_cnt[ch] = 0; rep_cnt[ch] = 0;
      rise_cyc[ch] = 0; fall_cyc[ch] = 0; age_m[ch] = 0;
    end

    for (int i = 0; i < 16; i++) begin
      tbl[i].r    = (i < 3);
      tbl[i].b    = (i >= 3 && i <= 9) ? 5'b00001 : 5'b00000;
      tbl[i].lvl  = (i >= 8 && i <= 14) ? 5'b00001 : 5'b00000;
      tbl[i].rise = (i == 8)  ? 5'b00001 : 5'b00000;
      tbl[i].fall = (i == 15) ? 5'b00001 : 5'b00000;
    end

    // reset then a clean press/release on channel 0
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].b);
      chk("tbl_level", 32'(btn_level), 32'(tbl[i].lvl));
      chk("tbl_rise",  32'(btn_rise),  32'(tbl[i].rise));
      chk("tbl_fall",  32'(btn_fall),  32'(tbl[i].fall));
    end
    repeat (8) step(1'b0, '0);

    // short glitch rejected, 4-cycle pulse accepted
    base = rise_cnt[1];
    repeat (3) step(1'b0, 5'b00010);
    repeat (10) step(1'b0, '0);
    chk("glitch3_no_rise", 32'(rise_cnt[1] - base), 32'd0);
    p = cyc + 1;
    repeat (4) step(1'b0, 5'b00010);
    repeat (10) step(1'b0, '0);
    chk("pulse4_rise_lat", 32'(rise_cyc[1] - p), 32'd5);
    chk("pulse4_fall_lat", 32'(fall_cyc[1] - (p + 4)), 32'd5);

    // simultaneous presses on channels 2 and 4
    repeat (5) step(1'b0, 5'b10100);
    step(1'b0, 5'b10100);
    chk("simul_rise", 32'(btn_rise), 32'(5'b10100));
    step(1'b0, 5'b10100);
    chk("simul_rise_clear", 32'(btn_rise), 32'd0);
    repeat (12) step(1'b0, '0);

    // reset mid-count with button held through release
    repeat (4) step(1'b0, 5'b01000);
    step(1'b1, 5'b01000);
    rc = cyc;
    chk("rst_level", 32'(btn_level), 32'd0);
    base = rise_cnt[3];
    repeat (8) step(1'b0, 5'b01000);
    chk("rst_release_lat", 32'(rise_cyc[3] - rc), 32'd6);
    chk("rst_release_once", 32'(rise_cnt[3] - base), 32'd1);
    repeat (10) step(1'b0, '0);

    // long hold on channel 0 for auto-repeat
    base = rep_cnt[0];
    p = cyc + 1;
    repeat (6) step(1'b0, 5'b00001);
    chk("hold_rise_lat", 32'(rise_cyc[0] - p), 32'd5);
    rc = rise_cyc[0];
    repeat (30) step(1'b0, 5'b00001);
    repeat (25) step(1'b0, '0);
    chk("hold_fall_lat", 32'(fall_cyc[0] - rc), 32'd36);
    chk("hold_repeat_count", 32'(rep_cnt[0] - base), REP_EN ? 32'd9 : 32'd0);

    // bounce train ending in a stable press on channel 1
    bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    base = rise_cnt[1];
    c5 = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) c5 = cyc + 1;
      step(1'b0, bounce[k] != 0 ? 5'b00010 : 5'b00000);
    end
    repeat (10) step(1'b0, 5'b00010);
    chk("bounce_single_rise", 32'(rise_cnt[1] - base), 32'd1);
    chk("bounce_rise_lat", 32'(rise_cyc[1] - c5), 32'd5);
    repeat (12) step(1'b0, '0);

    // randomized: slow per-channel toggling with occasional resets
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 7) == 0) cur[ch] = ~cur[ch];
      step($urandom_range(0, 299) == 0, cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
